// File: rtl/stack_client_pkg.sv
// Shared types and sizing for the stack client: state encoding, data width default,
// stack depth and the width of the phase counter.
package stack_client_pkg;

    localparam int DATA_W_DEFAULT    = 10;
    localparam int STACK_DEPTH       = 4;
    localparam int SETUP_CYC_DEFAULT = 1;
    localparam int PULSE_CYC_DEFAULT = 1;

    // The counter is loaded with (cycles - 1), so it only needs to hold max - 1.
    function automatic int phase_w(input int setup_cyc, input int pulse_cyc);
        int m;
        m = (setup_cyc > pulse_cyc) ? setup_cyc : pulse_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int PHASE_W = phase_w(SETUP_CYC_DEFAULT, PULSE_CYC_DEFAULT);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PUSH_SETUP,
        PUSH_PULSE,
        PUSH_HOLD,
        POP_PULSE,
        POP_REL,
        FINISH
    } state_t;

endpackage

// File: rtl/stack_client_phase_cnt.sv
// Loadable down-counter timing the SETUP and PULSE phases; last is high while the count is zero.
// Load takes effect on the next edge; the count then holds at zero until reloaded.
module stack_client_phase_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/stack_client.sv
// Initiator for the 4-deep edge-triggered LIFO: sequences push/pop/reset pulses and the shared bus.
// Push done 4 cycles after accept, pop 3 (defaults); STACK_CLIENT_GUARD_EN short-circuits full/empty ops.
module stack_client
    import stack_client_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int SETUP_CYC = SETUP_CYC_DEFAULT,
    parameter int PULSE_CYC = PULSE_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_push,
    input  logic              req_pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic              req_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              op_err,
    inout  logic [DATA_W-1:0] stk_data,
    output logic              stk_push,
    output logic              stk_pop,
    output logic              stk_reset,
    input  logic              stk_full,
    input  logic              stk_empty,
    input  logic              stk_err
);

    localparam int CNT_W = phase_w(SETUP_CYC, PULSE_CYC);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);

    state_t            state;
    logic [DATA_W-1:0] drive;
    logic              bus_oe;
    logic              push_go;
    logic              pop_go;
    logic              push_block;
    logic              pop_block;
    logic              phase_load;
    logic [CNT_W-1:0]  phase_val;
    logic              phase_last;

    assign push_go = (state == IDLE) && req_push;
    assign pop_go  = (state == IDLE) && req_pop && !req_push;

`ifdef STACK_CLIENT_GUARD_EN
    assign push_block = stk_full;
    assign pop_block  = stk_empty;
`else
    logic unused_flags;
    assign unused_flags = stk_full ^ stk_empty;
    assign push_block   = 1'b0;
    assign pop_block    = 1'b0;
`endif

    assign phase_load = push_go || pop_go || ((state == PUSH_SETUP) && phase_last);
    assign phase_val  = push_go ? SETUP_LOAD : PULSE_LOAD;

    stack_client_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .load     (phase_load),
        .load_val (phase_val),
        .last     (phase_last)
    );

    always_ff @(posedge clk) begin
        if (push_go) begin
            drive <= wr_data;
        end
    end

    assign stk_data = bus_oe ? drive : {DATA_W{1'bz}};

    // Outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            req_ready <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            op_err    <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_reset <= 1'b0;
            bus_oe    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                INIT: begin
                    if (!stk_reset) begin
                        stk_reset <= 1'b1;
                    end else begin
                        stk_reset <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (push_go) begin
                        req_ready <= 1'b0;
                        if (push_block) begin
                            state  <= FINISH;
                            done   <= 1'b1;
                            op_err <= 1'b1;
                        end else begin
                            state  <= PUSH_SETUP;
                            bus_oe <= 1'b1;
                        end
                    end else if (pop_go) begin
                        req_ready <= 1'b0;
                        if (pop_block) begin
                            state  <= FINISH;
                            done   <= 1'b1;
                            op_err <= 1'b1;
                        end else begin
                            state   <= POP_PULSE;
                            stk_pop <= 1'b1;
                        end
                    end
                end
                PUSH_SETUP: begin
                    if (phase_last) begin
                        state    <= PUSH_PULSE;
                        stk_push <= 1'b1;
                    end
                end
                PUSH_PULSE: begin
                    if (phase_last) begin
                        state    <= PUSH_HOLD;
                        stk_push <= 1'b0;
                    end
                end
                PUSH_HOLD: begin
                    state  <= FINISH;
                    bus_oe <= 1'b0;
                    done   <= 1'b1;
                    op_err <= stk_err;
                end
                POP_PULSE: begin
                    // Capture while the stack still drives; it floats on the pop negedge.
                    if (phase_last) begin
                        state   <= POP_REL;
                        stk_pop <= 1'b0;
                        rd_data <= stk_data;
                    end
                end
                POP_REL: begin
                    state  <= FINISH;
                    done   <= 1'b1;
                    op_err <= stk_err;
                end
                FINISH: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    op_err    <= 1'b0;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule
